// File: rtl/window_generator.sv
// rtl/window_generator.sv - raster-to-3x3-window front end with edge replication
module window_generator #(
   parameter int IMG_W = 128,
   parameter int IMG_H = 128,
   parameter int PIX_W = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [PIX_W-1:0]        pix_in,
   input  logic                    pix_valid,
   output logic                    pix_ready,
   output logic [8:0][PIX_W-1:0]   win_out,
   output logic                    win_valid,
   input  logic                    stall,
   output logic                    frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);
   localparam logic [CW-1:0] TWO_C  = CW'(2);
   localparam logic [RW-1:0] LAST_R = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ONE_R  = RW'(1);

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_EOL   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   logic [1:0]       state;
   logic [RW-1:0]    r;
   logic [CW-1:0]    c;
   logic [1:0]       rot;
   logic [1:0]       rot_nx, cur_i, prv_i;
   logic [PIX_W-1:0] mem [3][IMG_W];

   logic             load, accept, emit, last_win;
   logic [1:0]       ti, mi, bi;
   logic [CW-1:0]    x0, x1, x2;
   logic             use_pix;
   logic [8:0][PIX_W-1:0] win_next;

   assign load      = !win_valid || !stall;
   assign pix_ready = !reset && (state == S_RUN) && load;
   assign accept    = pix_valid && pix_ready;
   assign last_win  = (state == S_FLUSH) && (c == LAST_C);

   // rot is the row being written; the two rows before it sit one and two slots back
   assign rot_nx = (rot == 2'd2) ? 2'd0 : rot + 2'd1;
   assign cur_i  = (rot == 2'd0) ? 2'd2 : rot - 2'd1;
   assign prv_i  = rot_nx;

   always_comb begin
      emit = 1'b0;
      case (state)
         S_RUN:   emit = accept && (r != '0) && (c != '0);
         S_EOL:   emit = 1'b1;
         S_FLUSH: emit = 1'b1;
         default: emit = 1'b0;
      endcase
   end

   // Row above the centre clamps to row 0 while the centre is still in row 0
   always_comb begin
      ti      = (r == ONE_R) ? cur_i : prv_i;
      mi      = cur_i;
      bi      = rot;
      x0      = '0;
      x1      = '0;
      x2      = '0;
      use_pix = 1'b0;
      case (state)
         S_RUN: begin
            x0      = (c < TWO_C) ? '0 : c - TWO_C;
            x1      = (c == '0) ? '0 : c - 1'b1;
            x2      = c;
            use_pix = 1'b1;
         end
         S_EOL: begin
            x0 = LAST_C - 1'b1;
            x1 = LAST_C;
            x2 = LAST_C;
         end
         S_FLUSH: begin
            ti = prv_i;
            bi = cur_i;
            x0 = (c == '0) ? '0 : c - 1'b1;
            x1 = c;
            x2 = (c == LAST_C) ? LAST_C : c + 1'b1;
         end
         default: begin
            ti = prv_i;
         end
      endcase
      win_next[0] = mem[ti][x0];
      win_next[1] = mem[ti][x1];
      win_next[2] = mem[ti][x2];
      win_next[3] = mem[mi][x0];
      win_next[4] = mem[mi][x1];
      win_next[5] = mem[mi][x2];
      win_next[6] = mem[bi][x0];
      win_next[7] = mem[bi][x1];
      win_next[8] = use_pix ? pix_in : mem[bi][x2];
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[rot][c] <= pix_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_RUN;
         r          <= '0;
         c          <= '0;
         rot        <= 2'd0;
         win_valid  <= 1'b0;
         win_out    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (load) begin
            win_valid <= emit;
            if (emit) begin
               win_out <= win_next;
            end
            if (emit && last_win) begin
               frame_done <= 1'b1;
            end
         end
         case (state)
            S_RUN: begin
               if (accept) begin
                  if (c == LAST_C) begin
                     c <= '0;
                     if (r == '0) begin
                        r   <= ONE_R;
                        rot <= rot_nx;
                     end else begin
                        state <= S_EOL;
                     end
                  end else begin
                     c <= c + 1'b1;
                  end
               end
            end
            S_EOL: begin
               if (load) begin
                  rot <= rot_nx;
                  if (r == LAST_R) begin
                     state <= S_FLUSH;
                  end else begin
                     r     <= r + 1'b1;
                     state <= S_RUN;
                  end
               end
            end
            S_FLUSH: begin
               if (load) begin
                  if (c == LAST_C) begin
                     c     <= '0;
                     r     <= '0;
                     state <= S_RUN;
                  end else begin
                     c <= c + 1'b1;
                  end
               end
            end
            default: state <= S_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_window_generator.sv
// tb/tb_window_generator.sv - directed-vector bench for window_generator
module tb_window_generator;

   localparam int IW = 4;
   localparam int IH = 3;
   localparam int BOUND = 50;

   logic            clk;
   logic            reset;
   logic [7:0]      pix_in;
   logic            pix_valid;
   logic            pix_ready;
   logic [8:0][7:0] win_out;
   logic            win_valid;
   logic            stall;
   logic            frame_done;

   int n_vec = 0;
   int n_err = 0;
   int fd_cnt = 0;
   logic rdy_n = 1'b0;
   logic [71:0] got_q[$];
   bit          fd_q[$];

   window_generator #(.IMG_W(IW), .IMG_H(IH), .PIX_W(8)) dut (
      .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .win_out(win_out), .win_valid(win_valid),
      .stall(stall), .frame_done(frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      rdy_n <= pix_ready;
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (win_valid && !stall) begin
         got_q.push_back(win_out);
         fd_q.push_back(frame_done);
      end
   end

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [71:0] pack9(input int a0, input int a1, input int a2,
                                         input int a3, input int a4, input int a5,
                                         input int a6, input int a7, input int a8);
      return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
   endfunction

   function automatic logic [71:0] model_win(input int base, input int y, input int x);
      logic [71:0] w;
      int cy, cx;
      w = '0;
      for (int dy = 0; dy < 3; dy++) begin
         for (int dx = 0; dx < 3; dx++) begin
            cy = y + dy - 1;
            cx = x + dx - 1;
            if (cy < 0) cy = 0;
            if (cy > IH - 1) cy = IH - 1;
            if (cx < 0) cx = 0;
            if (cx > IW - 1) cx = IW - 1;
            w[(3*dy+dx)*8 +: 8] = 8'(base + 16*cy + cx);
         end
      end
      return w;
   endfunction

   // mode 1: row-end checks after pixel (1,3); mode 2: 5-cycle stall after pixel (2,2)
   task automatic send_pix(input int base, input int npix, input int mode);
      int n;
      for (int i = 0; i < npix; i++) begin
         pix_in    = 8'(base + 16*(i/IW) + i%IW);
         pix_valid = 1'b1;
         n = 0;
         do begin
            @(posedge clk);
            n++;
         end while (!rdy_n && n < BOUND);
         #1;
         if (!rdy_n) begin
            check("accept_timeout", 72'(0), 72'(1));
            pix_valid = 1'b0;
            return;
         end
         if (mode == 1 && i == 7) begin
            pix_valid = 1'b0;
            @(negedge clk);
            check("rowend_win02", win_out, pack9(1,2,3, 1,2,3, 17,18,19));
            check("rowend_rdy0", 72'(pix_ready), 72'(0));
            @(posedge clk); #1;
            @(negedge clk);
            check("rowend_win03", win_out, pack9(2,3,3, 2,3,3, 18,19,19));
            check("rowend_rdy1", 72'(pix_ready), 72'(1));
            @(posedge clk); #1;
         end
         if (mode == 2 && i == 10) begin
            stall = 1'b1;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check("stall_win11", win_out, pack9(0,1,2, 16,17,18, 32,33,34));
               check("stall_rdy", 72'(pix_ready), 72'(0));
               check("stall_valid", 72'(win_valid), 72'(1));
               @(posedge clk); #1;
            end
            stall = 1'b0;
         end
      end
   endtask

   task automatic wait_windows(input int q0, input int n);
      int k;
      k = 0;
      while (got_q.size() < q0 + n && k < 300) begin
         @(posedge clk);
         k++;
      end
      repeat (4) @(posedge clk);
      #1;
      check("win_count", 72'(got_q.size() - q0), 72'(n));
   endtask

   task automatic check_frame(input int base, input int q0);
      for (int i = 0; i < IW*IH; i++) begin
         if (q0 + i < got_q.size())
            check($sformatf("win_seq_%0d", i), got_q[q0+i], model_win(base, i/IW, i%IW));
      end
   endtask

   initial begin
      int q0, f0;
      reset     = 1'b1;
      pix_valid = 1'b0;
      pix_in    = 8'd0;
      stall     = 1'b0;

      // reset with random input activity
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         pix_valid = 1'($urandom_range(0, 1));
         pix_in    = 8'($urandom);
         @(negedge clk);
         check("rst_win_valid", 72'(win_valid), 72'(0));
         check("rst_win_out", win_out, 72'(0));
         check("rst_frame_done", 72'(frame_done), 72'(0));
         check("rst_pix_ready", 72'(pix_ready), 72'(0));
      end
      @(posedge clk); #1;
      reset     = 1'b0;
      pix_valid = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 72'(pix_ready), 72'(1));
      @(posedge clk); #1;

      // full frame, no stall, with row-end checks
      q0 = got_q.size();
      f0 = fd_cnt;
      send_pix(0, IW*IH, 1);
      pix_valid = 1'b0;
      wait_windows(q0, IW*IH);
      if (got_q.size() >= q0 + IW*IH) begin
         check("first_win", got_q[q0], pack9(0,0,1, 0,0,1, 16,16,17));
         check("last_win", got_q[q0+11], pack9(18,19,19, 34,35,35, 34,35,35));
         check("last_fd", 72'(fd_q[q0+11]), 72'(1));
      end
      check("fd_pulses_1", 72'(fd_cnt - f0), 72'(1));
      check_frame(0, q0);

      // full frame with a stall on window (1,1)
      q0 = got_q.size();
      f0 = fd_cnt;
      send_pix(0, IW*IH, 2);
      pix_valid = 1'b0;
      wait_windows(q0, IW*IH);
      check("fd_pulses_stall", 72'(fd_cnt - f0), 72'(1));
      check_frame(0, q0);

      // reset after accepting (1,2), then a fresh frame
      send_pix(0, 7, 0);
      reset     = 1'b1;
      pix_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("midrst_valid", 72'(win_valid), 72'(0));
      @(posedge clk); #1;
      q0 = got_q.size();
      send_pix(100, IW*IH, 0);
      pix_valid = 1'b0;
      wait_windows(q0, IW*IH);
      if (got_q.size() > q0)
         check("midrst_first", got_q[q0], pack9(100,100,101, 100,100,101, 116,116,117));
      check_frame(100, q0);

      // back-to-back frames with pix_valid held high
      q0 = got_q.size();
      f0 = fd_cnt;
      send_pix(0, IW*IH, 0);
      send_pix(100, IW*IH, 0);
      pix_valid = 1'b0;
      wait_windows(q0, 2*IW*IH);
      check("b2b_fd_pulses", 72'(fd_cnt - f0), 72'(2));
      if (got_q.size() > q0 + IW*IH)
         check("b2b_f2_first", got_q[q0+IW*IH], pack9(100,100,101, 100,100,101, 116,116,117));
      check_frame(0, q0);
      check_frame(100, q0 + IW*IH);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
